sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Two-port arbiter and timing sequencer for the external 16-bit asynchronous SRAM (18-bit address, active-low CS/OE/WE).
- Shares the single SRAM between two requesters, e.g. the SRAM self-test engine and the WS2812 frame-buffer reader.
- Round-robin arbitration, one complete access per grant, fixed access timing.
- Sits in top, between the requesters and the SRAM pins; top builds the tristate on the data bus from sram_dq_o/sram_dq_oe.

Parameters:
AW, 18, SRAM address width
DW, 16, SRAM data width
WAIT_CYCLES, 2, clk cycles OE/WE held active (≥1; 2 at 100 MHz for a 10 ns part)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req0  in  1  port 0 request; held until ack0
we0  in  1  port 0: 1=write, 0=read
addr0  in  AW  port 0 address
wdata0  in  DW  port 0 write data
ack0  out  1  port 0 completion pulse (1 cycle)
rdata0  out  DW  port 0 read data, valid while ack0=1
req1/we1/addr1/wdata1/ack1/rdata1  as port 0, for port 1
busy  out  1  1 whenever state≠IDLE
sram_a  out  AW  SRAM address
sram_dq_o  out  DW  data driven to SRAM
sram_dq_oe  out  1  1 = FPGA drives data bus
sram_dq_i  in  DW  data from SRAM bus
sram_cs  out  1  chip select, active low
sram_oe  out  1  output enable, active low
sram_we  out  1  write enable, active low

Behaviour:
- One clock domain. All outputs are registered. Async rst asserts all outputs immediately.
- Reset values: sram_cs=sram_oe=sram_we=1, sram_dq_oe=0, sram_a=0, sram_dq_o=0, ack0=ack1=0, rdata0=rdata1=0, busy=0, state=IDLE, last=1 (so port 0 wins first).
- FSM: IDLE → SETUP → ACCESS (WAIT_CYCLES cycles, counter) → END → IDLE.
- IDLE:
  - SRAM deselected, bus released.
  - On a clock edge with any reqN=1: pick winner. If only one port requests, grant it. If both request, grant the port ≠ last.
  - Latch winner id, we, addr, wdata; set last=winner; go to SETUP.
- SETUP (1 cycle):
  - sram_cs=0, sram_a=latched addr, oe=we=1.
  - Write: sram_dq_oe=1, sram_dq_o=wdata.
- ACCESS (WAIT_CYCLES cycles):
  - cs=0.
  - Read: oe=0, dq_oe=0.
  - Write: we=0, dq_oe=1.
  - Read: sram_dq_i is sampled on the last ACCESS edge into the winner's rdataN.
- END (1 cycle):
  - oe=we=1, cs=0. Write data stays driven (hold time).
  - ackN=1 for the winner only; rdataN stable.
- Timing: req sampled at edge 0 → ack high from edge WAIT_CYCLES+2 for one cycle. cs low WAIT_CYCLES+2 cycles.
- Throughput: back-to-back transactions start every WAIT_CYCLES+3 cycles, since IDLE always lasts ≥1 cycle.
- Requester rules:
  - req, we, addr and wdata must stay stable until ack.
  - The requester may keep req high to issue another access (contents may change after ack).
  - A req deasserted before grant is simply not served. A req deasserted after grant does not abort the access.
- rdataN holds its value until the next read on that port. A write never alters rdataN.
- Never both acks in the same cycle. Never we=0 and oe=0 simultaneously. dq_oe=0 whenever oe=0.
- Address wraps naturally; no range check.
- Reset mid-transaction: access aborted, SRAM deselected asynchronously, no ack issued. The written word is undefined and must not be relied on.

Test Plan:
1. Reset: assert rst mid-run → cs/oe/we=1, dq_oe=0, acks=0, busy=0 immediately; release, hold 10 cycles idle → outputs unchanged.
2. Single write: port 0 writes 0xA5C3 to 0x00123 → cs low 4 cycles, we low exactly cycles 2–3 after grant edge, dq_o=0xA5C3 during SETUP..END, ack0 one cycle at edge 4, ack1 stays 0.
3. Single read: SRAM model returns 0x5A5A at 0x3FFFF, port 1 reads → oe low 2 cycles, dq_oe=0 throughout, ack1 at edge 4 with rdata1=0x5A5A.
4. Contention: req0 and req1 held high from the same edge for 4 transactions → grant order 0,1,0,1, acks spaced 5 cycles apart; we/oe never both low.
5. Reset during a port 0 write's ACCESS → cs/we high asynchronously, no ack0; after release, simultaneous requests → port 0 served first.
6. Coherence: port 0 writes 0x1234 to 0x00010, then port 1 reads 0x00010 → rdata1=0x1234; rdata0 unchanged by the write.

Source files
------------

// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter and fixed-timing sequencer for an external
// asynchronous SRAM. Every SRAM-facing signal and every requester output is a flop.
module sram_arbiter #(
  parameter int AW          = 18,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_i,
  output logic          sram_cs,
  output logic          sram_oe,
  output logic          sram_we
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          win_q, win_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          cs_q, cs_d;
  logic          oe_q, oe_d;
  logic          we_q, we_d;
  logic          dq_oe_q, dq_oe_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] dq_o_q, dq_o_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          busy_q, busy_d;
  logic          grant1;

  // State register plus all datapath and output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cs_q     <= 1'b1;
      oe_q     <= 1'b1;
      we_q     <= 1'b1;
      dq_oe_q  <= 1'b0;
      a_q      <= '0;
      dq_o_q   <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      win_q    <= win_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cs_q     <= cs_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      dq_oe_q  <= dq_oe_d;
      a_q      <= a_d;
      dq_o_q   <= dq_o_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
    end
  end

  // On contention the port that was not served last wins.
  assign grant1 = req1 && (!req0 || !last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win_d   = win_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          win_d   = grant1;
          last_d  = grant1;
          wr_d    = grant1 ? we1 : we0;
          addr_d  = grant1 ? addr1 : addr0;
          wdata_d = grant1 ? wdata1 : wdata0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q == CNT_LAST) state_d = S_END;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pins follow the phase held in state_q one cycle later, so each SRAM
  // phase is seen on the bus for exactly the cycles that phase lasts.
  always_comb begin
    cs_d     = 1'b1;
    oe_d     = 1'b1;
    we_d     = 1'b1;
    dq_oe_d  = 1'b0;
    a_d      = a_q;
    dq_o_d   = dq_o_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    busy_d   = (state_d != S_IDLE);
    case (state_q)
      S_SETUP: begin
        cs_d    = 1'b0;
        a_d     = addr_q;
        dq_oe_d = wr_q;
        if (wr_q) dq_o_d = wdata_q;
      end
      S_ACCESS: begin
        cs_d    = 1'b0;
        oe_d    = wr_q;
        we_d    = !wr_q;
        dq_oe_d = wr_q;
      end
      S_END: begin
        cs_d    = 1'b0;
        dq_oe_d = wr_q;
        ack0_d  = !win_q;
        ack1_d  = win_q;
        if (!wr_q) begin
          if (win_q) rdata1_d = sram_dq_i;
          else       rdata0_d = sram_dq_i;
        end
      end
      default: ;
    endcase
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign busy       = busy_q;
  assign sram_a     = a_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_cs    = cs_q;
  assign sram_oe    = oe_q;
  assign sram_we    = we_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural asynchronous SRAM;
// outputs are sampled on the falling clock edge.
module tb_sram_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_cs, sram_oe, sram_we;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  sram_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we)
  );

  // SRAM model: read is combinational while selected, write lands on rising WE.
  assign sram_dq_i = (!sram_cs && !sram_oe) ? mem[sram_a] : '0;
  always @(posedge sram_we) begin
    if (sram_cs === 1'b0) mem[sram_a] <= sram_dq_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Waits for an ack on the given port; records which cycle it came in.
  task automatic wait_ack(input int port, input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if ((port == 0) ? ack0 : ack1) begin
        cyc = i;
        break;
      end
    end
    chk("ack_seen", {31'd0, cyc >= 0}, 32'd1);
  endtask

  int cyc;
  int ack_port[$];
  int ack_cyc[$];
  logic exp_cs, exp_we, exp_oe, exp_dq_oe, exp_ack;

  initial begin
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    mem[18'h3FFFF] = 16'h5A5A;
    repeat (3) step();

    // Reset values, then ten idle cycles with nothing moving.
    chk("rst_ctrl", {25'd0, sram_cs, sram_oe, sram_we, sram_dq_oe, ack0, ack1, busy}, 32'b1110000);
    chk("rst_a", {14'd0, sram_a}, 32'd0);
    chk("rst_dq_o", {16'd0, sram_dq_o}, 32'd0);
    chk("rst_rdata", {rdata0, rdata1}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_ctrl", {25'd0, sram_cs, sram_oe, sram_we, sram_dq_oe, ack0, ack1, busy}, 32'b1110000);
    end

    // Single write on port 0; k counts edges after the grant edge.
    req0 = 1; we0 = 1; addr0 = 18'h00123; wdata0 = 16'hA5C3;
    for (int k = 0; k <= 5; k++) begin
      step();
      exp_cs    = !(k >= 1 && k <= 4);
      exp_we    = !(k == 2 || k == 3);
      exp_dq_oe = (k >= 1 && k <= 4);
      exp_ack   = (k == 4);
      chk("wr_cs", {31'd0, sram_cs}, {31'd0, exp_cs});
      chk("wr_we", {31'd0, sram_we}, {31'd0, exp_we});
      chk("wr_oe", {31'd0, sram_oe}, 32'd1);
      chk("wr_dq_oe", {31'd0, sram_dq_oe}, {31'd0, exp_dq_oe});
      chk("wr_ack0", {31'd0, ack0}, {31'd0, exp_ack});
      chk("wr_ack1", {31'd0, ack1}, 32'd0);
      if (k >= 1 && k <= 4) begin
        chk("wr_dq_o", {16'd0, sram_dq_o}, 32'h0000A5C3);
        chk("wr_a", {14'd0, sram_a}, 32'h00123);
      end
      if (k == 1) chk("wr_busy", {31'd0, busy}, 32'd1);
      if (k == 4) req0 = 0;
    end
    chk("wr_mem", {16'd0, mem[18'h00123]}, 32'h0000A5C3);

    // Single read on port 1 from the top address.
    req1 = 1; we1 = 0; addr1 = 18'h3FFFF;
    for (int k = 0; k <= 5; k++) begin
      step();
      exp_cs  = !(k >= 1 && k <= 4);
      exp_oe  = !(k == 2 || k == 3);
      exp_ack = (k == 4);
      chk("rd_cs", {31'd0, sram_cs}, {31'd0, exp_cs});
      chk("rd_oe", {31'd0, sram_oe}, {31'd0, exp_oe});
      chk("rd_we", {31'd0, sram_we}, 32'd1);
      chk("rd_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      chk("rd_ack1", {31'd0, ack1}, {31'd0, exp_ack});
      chk("rd_ack0", {31'd0, ack0}, 32'd0);
      if (k >= 1 && k <= 4) chk("rd_a", {14'd0, sram_a}, 32'h3FFFF);
      if (k == 4) begin
        chk("rd_rdata1", {16'd0, rdata1}, 32'h00005A5A);
        req1 = 0;
      end
    end

    // Contention: both ports held, four transactions.
    req0 = 1; we0 = 0; addr0 = 18'h00123;
    req1 = 1; we1 = 0; addr1 = 18'h3FFFF;
    for (int i = 0; i < 30 && ack_port.size() < 4; i++) begin
      step();
      chk("ct_excl_ack", {31'd0, ack0 && ack1}, 32'd0);
      chk("ct_excl_weoe", {31'd0, !sram_we && !sram_oe}, 32'd0);
      if (ack0) begin
        ack_port.push_back(0); ack_cyc.push_back(i);
        chk("ct_rdata0", {16'd0, rdata0}, 32'h0000A5C3);
      end
      if (ack1) begin
        ack_port.push_back(1); ack_cyc.push_back(i);
        chk("ct_rdata1", {16'd0, rdata1}, 32'h00005A5A);
      end
    end
    req0 = 0; req1 = 0;
    chk("ct_count", ack_port.size(), 32'd4);
    if (ack_port.size() == 4) begin
      chk("ct_order", {ack_port[0][7:0], ack_port[1][7:0], ack_port[2][7:0], ack_port[3][7:0]},
          32'h00010001);
      chk("ct_first", ack_cyc[0], 32'd4);
      for (int j = 1; j < 4; j++) chk("ct_space", ack_cyc[j] - ack_cyc[j-1], 32'd5);
    end
    step();

    // Reset during the ACCESS phase of a port 0 write.
    req0 = 1; we0 = 1; addr0 = 18'h00200; wdata0 = 16'hBEEF;
    repeat (3) step();
    chk("ab_we_low", {31'd0, sram_we}, 32'd0);
    #2 rst = 1'b1;
    #1 chk("ab_async", {25'd0, sram_cs, sram_oe, sram_we, sram_dq_oe, ack0, ack1, busy}, 32'b1110000);
    req0 = 0;
    step();
    chk("ab_no_ack", {30'd0, ack0, ack1}, 32'd0);
    rst = 1'b0;
    req0 = 1; we0 = 0; addr0 = 18'h00123;
    req1 = 1; we1 = 0; addr1 = 18'h3FFFF;
    wait_ack(0, 10, cyc);
    chk("ab_first_port0", {31'd0, ack1}, 32'd0);
    chk("ab_rdata0", {16'd0, rdata0}, 32'h0000A5C3);
    req0 = 0; req1 = 0;
    step();

    // Coherence between ports; a write leaves rdata0 alone.
    req0 = 1; we0 = 1; addr0 = 18'h00010; wdata0 = 16'h1234;
    wait_ack(0, 10, cyc);
    chk("co_rdata0_kept", {16'd0, rdata0}, 32'h0000A5C3);
    req0 = 0;
    step();
    req1 = 1; we1 = 0; addr1 = 18'h00010;
    wait_ack(1, 10, cyc);
    chk("co_rdata1", {16'd0, rdata1}, 32'h00001234);
    chk("co_rdata0_still", {16'd0, rdata0}, 32'h0000A5C3);
    req1 = 0;
    repeat (2) step();
    chk("co_idle", {25'd0, sram_cs, sram_oe, sram_we, sram_dq_oe, ack0, ack1, busy}, 32'b1110000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
